// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//  Bundles the arbiter's request/grant signals.
//  The requesting agents use the master modport.
//  The arbiter uses the slave modport.
//  Signals:
//   req     [N]   request vector, bit k = requester k wants the mux
//   rel           owner release strobe
//   grant   [N]   one-hot grant, zero when idle
//   sel     [SW]  index of current owner, drives mux32.s
//   valid         grant held, sel meaningful
//   timeout       one-cycle pulse on forced release
interface mux_rr_arbiter_if #(
    parameter int N  = 32,
    parameter int SW = 5
);
    logic [N-1:0]  req;
    logic          rel;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          valid;
    logic          timeout;

    modport master (output req, rel, input grant, sel, valid, timeout);
    modport slave  (input req, rel, output grant, sel, valid, timeout);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//  Round-robin arbiter and select sequencer for the shared 32:1 bit mux.
//  One requester is granted at a time. The winner's index drives the mux
//  select until the owner releases it or drops its request. There is always
//  one dead cycle (valid=0) between consecutive grants.
//
//  Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus.req    request vector (N)
//   bus.rel    release strobe, only looked at while a grant is held
//   bus.grant  registered one-hot grant, zero when idle
//   bus.sel    owner index; keeps the last winner after release
//   bus.valid  high while a grant is held
//   bus.timeout  one-cycle pulse on a forced release
//
//  Optional feature: define MUX_ARB_TIMEOUT_EN to limit each grant to
//  MAX_HOLD cycles. Without it, timeout is tied low.
module mux_rr_arbiter #(
    parameter int N        = 32,
    parameter int SW       = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_rr_arbiter_if.slave      bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q;
    logic [N-1:0]  grant_q;
    logic [SW-1:0] sel_q;
    logic          valid_q;
    logic [SW-1:0] ptr_q;

    // Candidate list, rotated so that position 0 is the pointer.
    // Each index is wrapped mod N explicitly, so N need not be a power of two.
    logic [SW:0]   cand_sum [N];
    logic [SW-1:0] cand_idx [N];
    logic [N-1:0]  cand_req;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, ptr_q} + (SW+1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= (SW+1)'(N))
                            ? SW'(cand_sum[gi] - (SW+1)'(N))
                            : cand_sum[gi][SW-1:0];
        assign cand_req[gi] = bus.req[cand_idx[gi]];
    end

    logic [SW-1:0] win_d;
    logic [SW-1:0] ptr_d;

    // The scan runs from the far end, so the lowest rotated position wins.
    always_comb begin
        win_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win_d = cand_idx[i];
            end
        end
    end

    assign ptr_d = (win_d == SW'(N - 1)) ? '0 : win_d + 1'b1;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_cnt_q;
    logic          timeout_q;
`endif

    // Owner exit: an explicit release, or the owner dropped its own request.
    logic owner_exit;
    assign owner_exit = bus.rel || !bus.req[sel_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q <= BUSY;
                        grant_q <= {{(N-1){1'b0}}, 1'b1} << win_d;
                        sel_q   <= win_d;
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_d;
`ifdef MUX_ARB_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end
                end
                BUSY: begin
                    // sel_q is deliberately left alone on exit so the mux
                    // select does not glitch.
                    if (owner_exit) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
                    end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
`ifdef MUX_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
    localparam int N  = 32;
    localparam int SW = 5;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N), .SW(SW)) bus ();

    mux_rr_arbiter #(.N(N), .SW(SW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int seq [17] = '{2, 3, 6, 7, 10, 11, 14, 15, 18, 19, 22, 23, 26, 27, 30, 31, 2};

    initial begin
        bus.req = '1;
        bus.rel = 1'b0;

        // 1: reset with every request pending
        do_reset();
        check("rst_grant", bus.grant, 32'h0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);

        // 2: single request and release
        bus.req = 32'h0000_0010;
        step();
        $display("grant sel=%0d valid=%0b", bus.sel, bus.valid);
        check("t2_grant", bus.grant, 32'h0000_0010);
        check("t2_sel", 32'(bus.sel), 32'd4);
        check("t2_valid", 32'(bus.valid), 32'd1);
        bus.rel = 1'b1;
        bus.req = '0;
        step();
        bus.rel = 1'b0;
        check("t2_rel_valid", 32'(bus.valid), 32'd0);
        check("t2_rel_grant", bus.grant, 32'h0);
        check("t2_rel_sel", 32'(bus.sel), 32'd4);

        // 3: round-robin across a fixed pattern, starting from the reset pointer
        do_reset();
        bus.req = 32'hCCCC_CCCC;
        for (int k = 0; k < 17; k++) begin
            step();
            $display("grant sel=%0d valid=%0b", bus.sel, bus.valid);
            check($sformatf("t3_sel%0d", k), 32'(bus.sel), 32'(seq[k]));
            check($sformatf("t3_valid%0d", k), 32'(bus.valid), 32'd1);
            check($sformatf("t3_grant%0d", k), bus.grant, 32'h1 << seq[k]);
            bus.rel = 1'b1;
            step();
            bus.rel = 1'b0;
            check($sformatf("t3_dead%0d", k), 32'(bus.valid), 32'd0);
        end
        bus.req = '0;
        step();

        // 4: owner drop, then release coinciding with a new request
        bus.req = 32'h1 << 5;
        step();
        check("t4_sel5", 32'(bus.sel), 32'd5);
        bus.req = '0;
        step();
        check("t4_drop_valid", 32'(bus.valid), 32'd0);
        bus.req = 32'h1 << 5;
        step();
        check("t4_regrant5", 32'(bus.sel), 32'd5);
        bus.rel = 1'b1;
        bus.req = (32'h1 << 5) | (32'h1 << 9);
        step();
        bus.rel = 1'b0;
        bus.req = 32'h1 << 9;
        check("t4_dead_valid", 32'(bus.valid), 32'd0);
        check("t4_dead_grant", bus.grant, 32'h0);
        step();
        $display("grant sel=%0d valid=%0b", bus.sel, bus.valid);
        check("t4_sel9", 32'(bus.sel), 32'd9);
        check("t4_valid9", 32'(bus.valid), 32'd1);

        // 5: reset mid-grant clears the pointer
        bus.rel = 1'b1;
        bus.req = '0;
        step();
        bus.rel = 1'b0;
        bus.req = 32'h1 << 20;
        step();
        check("t5_sel20", 32'(bus.sel), 32'd20);
        rst = 1'b1;
        step();
        check("t5_rst_grant", bus.grant, 32'h0);
        check("t5_rst_sel", 32'(bus.sel), 32'd0);
        check("t5_rst_valid", 32'(bus.valid), 32'd0);
        rst = 1'b0;
        bus.req = 32'h8010_0001;
        step();
        check("t5_first_sel", 32'(bus.sel), 32'd0);
        check("t5_first_grant", bus.grant, 32'h1);
        bus.rel = 1'b1;
        step();
        bus.rel = 1'b0;
        step();
        check("t5_next_sel", 32'(bus.sel), 32'd20);

        // 6: hold limit behaviour
        bus.req = '0;
        do_reset();
        bus.req = 32'h1;
`ifdef MUX_ARB_TIMEOUT_EN
        for (int k = 0; k < MH; k++) begin
            step();
            check($sformatf("t6_hold%0d", k), 32'(bus.valid), 32'd1);
            check($sformatf("t6_noto%0d", k), 32'(bus.timeout), 32'd0);
        end
        step();
        check("t6_to_valid", 32'(bus.valid), 32'd0);
        check("t6_to_pulse", 32'(bus.timeout), 32'd1);
        step();
        check("t6_regrant", 32'(bus.valid), 32'd1);
        check("t6_regrant_sel", 32'(bus.sel), 32'd0);
        check("t6_to_clear", 32'(bus.timeout), 32'd0);
`else
        for (int k = 0; k < 3 * MH; k++) begin
            step();
            check($sformatf("t6_hold%0d", k), 32'(bus.valid), 32'd1);
            check($sformatf("t6_noto%0d", k), 32'(bus.timeout), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
